ram_stream_reader: RTL

Read-side sequencer for the team's single-clock synchronous-read RAM blocks (one-cycle registered read, no read enable). It accepts a base address and word count, drives the RAM read address, and streams the returned words out over a valid/ready interface with full backpressure. Its internal buffering keeps throughput at one word per cycle while the consumer is ready.

---
 rtl/ram_stream_reader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side sequencer for single-clock synchronous-read RAMs (one-cycle
//   registered read, no read enable). A command (base_addr, len) is sampled
//   with start. The block then drives the RAM read address and streams the
//   returned words out over a valid/ready interface with full backpressure.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   command strobe, sampled only while busy=0
//   base_addr  in   first RAM address, sampled with start
//   len        in   number of words (0 .. 2^(ADDR_LENGTH+1)-1), sampled with start
//   busy       out  transfer in progress
//   done       out  one-cycle pulse at end of transfer
//   r_addr     out  registered RAM read address
//   r_data     in   RAM read data, valid one cycle after r_addr
//   m_data     out  stream data (FIFO head)
//   m_valid    out  stream data valid
//   m_ready    in   consumer ready
//   abort      in   cancel transfer (only with RAM_READER_ABORT_EN)
//
// Build option
//   RAM_READER_ABORT_EN : adds the abort port and the flush/cancel logic.

module ram_stream_reader #(
    parameter int WORD_LENGTH = 8,
    parameter int ADDR_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_LENGTH-1:0] base_addr,
    input  logic [ADDR_LENGTH:0]   len,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_LENGTH-1:0] r_addr,
    input  logic [WORD_LENGTH-1:0] r_data,
    output logic [WORD_LENGTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready
`ifdef RAM_READER_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam int FIFO_DEPTH = 4;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [ADDR_LENGTH:0]   r_issue_rem;
    logic [ADDR_LENGTH:0]   r_accept_rem;
    // r_tag_addr: the address on r_addr this cycle is a live issue.
    // r_tag_data: the word on r_data this cycle belongs to a live issue.
    logic                   r_tag_addr;
    logic                   r_tag_data;
    logic [WORD_LENGTH-1:0] r_fifo [FIFO_DEPTH];
    logic [1:0]             r_wr_ptr;
    logic [1:0]             r_rd_ptr;
    logic [2:0]             r_count;
    logic                   r_done;

    logic                   w_start_go;
    logic                   w_start_empty;
    logic                   w_issue;
    logic                   w_last;
    logic                   w_xfer;
    logic                   w_push;
    logic                   w_abort_hit;
    logic [2:0]             w_outstanding;

`ifdef RAM_READER_ABORT_EN
    assign w_abort_hit = abort && (r_state == ST_RUN);
`else
    assign w_abort_hit = 1'b0;
`endif

    assign m_valid       = (r_count != 3'd0);
    assign m_data        = r_fifo[r_rd_ptr];
    assign busy          = (r_state == ST_RUN);
    assign done          = r_done;
    assign w_xfer        = m_valid && m_ready;
    assign w_push        = r_tag_data;
    // Pipeline words plus buffered words; capping this at the FIFO depth
    // guarantees every in-flight word has a FIFO slot when it lands.
    assign w_outstanding = r_count + {2'b00, r_tag_addr} + {2'b00, r_tag_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_start_go    = 1'b0;
        w_start_empty = 1'b0;
        w_issue       = 1'b0;
        w_last        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_start_go   = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_start_empty = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_abort_hit) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_issue = (r_issue_rem != '0) && (w_outstanding < 3'(FIFO_DEPTH));
                    if (w_xfer && (r_accept_rem == (ADDR_LENGTH+1)'(1))) begin
                        w_last       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_issue_rem  <= '0;
            r_accept_rem <= '0;
            r_tag_addr   <= 1'b0;
            r_tag_data   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_done       <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_done     <= w_start_empty || w_last || w_abort_hit;
            r_tag_data <= r_tag_addr;
            r_tag_addr <= w_start_go || w_issue;

            if (w_xfer) begin
                r_accept_rem <= r_accept_rem - (ADDR_LENGTH+1)'(1);
                r_rd_ptr     <= r_rd_ptr + 2'd1;
            end

            // Loading base_addr is itself issue #1.
            if (w_start_go) begin
                r_addr       <= base_addr;
                r_issue_rem  <= len - (ADDR_LENGTH+1)'(1);
                r_accept_rem <= len;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_LENGTH'(1);
                r_issue_rem <= r_issue_rem - (ADDR_LENGTH+1)'(1);
            end

            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_data;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end

            case ({w_push, w_xfer})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase

            // Abort overrides everything above: drop buffered and in-flight words.
            if (w_abort_hit) begin
                r_issue_rem  <= '0;
                r_accept_rem <= '0;
                r_tag_addr   <= 1'b0;
                r_tag_data   <= 1'b0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
            end
        end
    end

endmodule
